pin_mux_cfg: RTL
================

Name: pin_mux_cfg

Overview:
- Configuration controller that owns the sel0/sel1 selection inputs of the pin multiplexer.
- Software writes shadow selection registers over a simple single-cycle register bus, then issues a commit.
- On commit, the block runs a glitch-free switch sequence. Every pad whose function changes is held tristated (oeb_force) for a guard interval before and after the new selection is applied.
- oeb_force is ORed with the mux io_oeb at the top level.

Parameters:
- COUNT, 32, number of pads (1..32); one sel0/sel1 bit pair per pad.
- GUARD, 4, guard interval in clk cycles before and after the selection switch (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  register write strobe, single cycle
- rd_en  input  1  register read strobe
- addr  input  3  register address
- wdata  input  32  write data
- rdata  output  32  read data (combinational from addr when rd_en, else 0)
- sel0  output  COUNT  active selection bit 0 per pad, registered
- sel1  output  COUNT  active selection bit 1 per pad, registered
- oeb_force  output  COUNT  1 = force pad output disabled
- busy  output  1  switch sequence in progress
- done  output  1  one-cycle pulse when a commit completes

Behaviour:
- Register map:
  - 0 SH_SEL0 (R/W)
  - 1 SH_SEL1 (R/W)
  - 2 ACT_SEL0 (RO)
  - 3 ACT_SEL1 (RO)
  - 4 CTRL/STATUS: write bit0=1 commits; read bit0=busy, bit1=pending
  - 5..7: reads return 0, writes are ignored.
- Bits above COUNT-1 are ignored on write and read as 0. Writes to RO registers are ignored.
- Reset (rst_n low, async): shadows, sel0, sel1, oeb_force, busy, done, pending, counter and mask all 0; FSM goes to IDLE.
- FSM states: IDLE, OFF, SWITCH, SETTLE.
- IDLE: a commit (write addr 4, bit0=1) at cycle T, or pending=1, starts a sequence:
  - snapshot the shadows into snap0/snap1;
  - mask = (snap0^sel0)|(snap1^sel1);
  - clear pending.
- If mask==0 at start: no forcing; done pulses at T+1; busy stays 0.
- Otherwise:
  - T+1: enter OFF; oeb_force=mask; busy=1; counter=GUARD-1.
  - OFF lasts GUARD cycles (T+1..T+GUARD), then goes to SWITCH.
  - SWITCH, 1 cycle (T+GUARD+1): sel0<=snap0, sel1<=snap1; new values are visible from T+GUARD+2.
  - SETTLE lasts GUARD cycles (T+GUARD+2..T+2*GUARD+1), then goes to IDLE.
  - T+2*GUARD+2: oeb_force=0, busy=0, done=1 for one cycle.
- Unchanged pads never see oeb_force asserted and never see sel change.
- Commit while busy sets pending (one deep; extra commits while pending=1 are absorbed). The pending sequence starts in the IDLE cycle after done, using the shadow values at that time.
- Shadow writes while busy are allowed and do not affect the running sequence, which uses its snapshot.
- Commit with bit0=0 does nothing.
- Asserting reset mid-sequence aborts immediately: all outputs go to 0, including oeb_force and sel.
- rdata is a pure function of addr and current register state; a read in the same cycle as a write returns the old value.

Test Plan:
- Reset: assert rst_n=0 mid-OFF -> sel0=sel1=oeb_force=0, busy=0 asynchronously; reads of addr 0..4 return 0.
- Single pad change (GUARD=4, COUNT=32): write SH_SEL0=0x1, commit at T -> oeb_force=0x1 over T+1..T+9; sel0=0x1 from T+6; done at T+10; busy falls at T+10.
- No-op commit: commit with shadows equal to active -> done at T+1, busy never 1, oeb_force stays 0.
- Multi-pad partial change: active sel0=0xF0, sel1=0; shadow sel0=0xF0, sel1=0x0F, commit -> oeb_force=0x0F only; ACT_SEL1 reads 0x0F after done; pads 4..7 never forced.
- Pending commit: commit, then at T+3 write SH_SEL0=0x2 and commit again -> STATUS pending=1; second sequence starts right after the first done; final ACT_SEL0=0x2; two done pulses.
- Width masking (COUNT=8): write SH_SEL0=0xFFFFFFFF -> reads back 0xFF; addr 6 reads 0; writes to addr 2 are ignored.

Source files
------------

// File: rtl/pin_mux_cfg_if.sv
// Register bus between software and the pin-mux configuration block.
// Single-cycle strobes; rdata is combinational, so there is no backpressure.
interface pin_mux_cfg_if;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output wr_en, rd_en, addr, wdata, input rdata);
   modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/pin_mux_cfg.sv
// Shadowed sel0/sel1 pin-mux selection with a glitch-free commit sequence.
// Commit at T: done at T+1 if nothing changes, else sel switches at T+GUARD+1 and done at T+2*GUARD+2.
module pin_mux_cfg #(
   parameter int COUNT = 32,
   parameter int GUARD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   pin_mux_cfg_if.slave     bus,
   output logic [COUNT-1:0] sel0,
   output logic [COUNT-1:0] sel1,
   output logic [COUNT-1:0] oeb_force,
   output logic             busy,
   output logic             done
);
   localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;

   typedef enum logic [1:0] {IDLE, OFF, SWITCH, SETTLE} state_t;

   state_t           state;
   logic [COUNT-1:0] sh0, sh1, snap0, snap1;
   logic [CW-1:0]    cnt;
   logic             pending;
   logic             commit;
   logic [COUNT-1:0] new_mask;
   logic [31:0]      rd;

   assign commit   = bus.wr_en && (bus.addr == 3'd4) && bus.wdata[0];
   assign new_mask = (sh0 ^ sel0) | (sh1 ^ sel1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sh0       <= '0;
         sh1       <= '0;
         snap0     <= '0;
         snap1     <= '0;
         sel0      <= '0;
         sel1      <= '0;
         oeb_force <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pending   <= 1'b0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         if (bus.wr_en && bus.addr == 3'd0) sh0 <= bus.wdata[COUNT-1:0];
         if (bus.wr_en && bus.addr == 3'd1) sh1 <= bus.wdata[COUNT-1:0];
         // Only one commit can queue behind a running sequence.
         if (commit && state != IDLE) pending <= 1'b1;

         case (state)
            IDLE: begin
               if (commit || pending) begin
                  snap0   <= sh0;
                  snap1   <= sh1;
                  pending <= 1'b0;
                  if (new_mask == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= OFF;
                     oeb_force <= new_mask;
                     busy      <= 1'b1;
                     cnt       <= CW'(GUARD - 1);
                  end
               end
            end
            OFF: begin
               if (cnt == '0) state <= SWITCH;
               else           cnt   <= cnt - 1'b1;
            end
            SWITCH: begin
               // Unchanged pads carry identical snapshot bits, so they never toggle.
               sel0  <= snap0;
               sel1  <= snap1;
               cnt   <= CW'(GUARD - 1);
               state <= SETTLE;
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state     <= IDLE;
                  oeb_force <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd = '0;
      if (bus.rd_en) begin
         case (bus.addr)
            3'd0:    rd[COUNT-1:0] = sh0;
            3'd1:    rd[COUNT-1:0] = sh1;
            3'd2:    rd[COUNT-1:0] = sel0;
            3'd3:    rd[COUNT-1:0] = sel1;
            3'd4:    rd[1:0]       = {pending, busy};
            default: rd = '0;
         endcase
      end
   end

   assign bus.rdata = rd;
endmodule
